adf4158_ctrl: RTL and testbench

Power-up configuration controller for the ADF4158 FMCW ramp synthesizer. After reset it enables the chip, waits a settling interval, then serially writes the ten-word register image (R7, R6 ×2, R5 ×2, R4, R3, R2, R1, R0) over the 3-wire interface (clock, data, load-enable). It then idles with `done_o` high. It sits between the FPGA system clock domain and the synthesizer pins on the FMCW board.

---
 rtl/adf4158_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_adf4158_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adf4158_ctrl.sv
// ADF4158 power-up controller: chip enable, settle, then 10 serial register writes.
// Optional macro ADF4158_TXDATA_EN enables the txdata_o ramp-trigger square wave.
module adf4158_ctrl #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned INIT_WAIT = 16,
    parameter int unsigned RAMP_HALF = 1000,
    parameter logic [31:0] R7  = 32'h0000_0007,
    parameter logic [31:0] R6A = 32'h0000_1F46,
    parameter logic [31:0] R6B = 32'h0080_1F46,
    parameter logic [31:0] R5A = 32'h0000_0FFD,
    parameter logic [31:0] R5B = 32'h0080_0005,
    parameter logic [31:0] R4  = 32'h0018_0104,
    parameter logic [31:0] R3  = 32'h0000_0443,
    parameter logic [31:0] R2  = 32'h0700_800A,
    parameter logic [31:0] R1  = 32'h0000_0001,
    parameter logic [31:0] R0  = 32'h8030_0000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic ce_o,
    output logic le_o,
    output logic clk_o,
    output logic data_o,
    output logic txdata_o,
    output logic done_o
);

    typedef enum logic [2:0] {
        S_INIT, S_SHIFT, S_LATCH, S_GAP, S_DONE
    } state_t;

    localparam int unsigned CMAX = (INIT_WAIT > DIV) ? INIT_WAIT : DIV;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] C_INIT = CW'(INIT_WAIT);
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] C_HIGH = CW'(DIV / 2 - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic          ce_q, ce_d;
    logic          le_q, le_d;
    logic          sclk_q, sclk_d;
    logic          data_q, data_d;
    logic          done_q, done_d;
    logic [31:0]   cur_w, nxt_w;

    function automatic logic [31:0] word_at(input logic [3:0] i);
        case (i)
            4'd0:    word_at = R7;
            4'd1:    word_at = R6A;
            4'd2:    word_at = R6B;
            4'd3:    word_at = R5A;
            4'd4:    word_at = R5B;
            4'd5:    word_at = R4;
            4'd6:    word_at = R3;
            4'd7:    word_at = R2;
            4'd8:    word_at = R1;
            default: word_at = R0;
        endcase
    endfunction

    assign cur_w = word_at(idx_q);
    assign nxt_w = word_at(idx_q + 4'd1);

    // Sequencer next-state: data only changes on the clk_o falling phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        ce_d    = ce_q;
        le_d    = le_q;
        sclk_d  = sclk_q;
        data_d  = data_q;
        done_d  = done_q;
        case (state_q)
            S_INIT: begin
                ce_d = 1'b1;
                if (cnt_q == C_INIT) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 5'd31;
                    idx_d   = 4'd0;
                    sclk_d  = 1'b0;
                    data_d  = R7[31];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q == C_LAST) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 5'd0) begin
                        state_d = S_LATCH;
                        le_d    = 1'b1;
                        data_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q - 5'd1;
                        data_d = cur_w[bit_q - 5'd1];
                    end
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    sclk_d = (cnt_q >= C_HIGH);
                end
            end
            S_LATCH: begin
                if (cnt_q == C_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    le_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == C_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 4'd9) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SHIFT;
                        idx_d   = idx_q + 4'd1;
                        bit_d   = 5'd31;
                        data_d  = nxt_w[31];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                ce_d   = 1'b1;
                le_d   = 1'b0;
                sclk_d = 1'b0;
                data_d = 1'b0;
                done_d = 1'b1;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Sequencer registers; every pin output comes straight from a flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            bit_q   <= 5'd31;
            idx_q   <= 4'd0;
            ce_q    <= 1'b0;
            le_q    <= 1'b0;
            sclk_q  <= 1'b0;
            data_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            ce_q    <= ce_d;
            le_q    <= le_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign ce_o   = ce_q;
    assign le_o   = le_q;
    assign clk_o  = sclk_q;
    assign data_o = data_q;
    assign done_o = done_q;

`ifdef ADF4158_TXDATA_EN
    localparam int unsigned RW = $clog2(RAMP_HALF + 1);
    localparam logic [RW-1:0] R_LAST = RW'(RAMP_HALF - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          tx_q, tx_d;

    // Ramp trigger: toggle every RAMP_HALF cycles once programming is done.
    always_comb begin
        rcnt_d = rcnt_q;
        tx_d   = tx_q;
        if (done_q) begin
            if (rcnt_q == R_LAST) begin
                rcnt_d = '0;
                tx_d   = ~tx_q;
            end else begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end
    end

    // Ramp trigger registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rcnt_q <= '0;
            tx_q   <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            tx_q   <= tx_d;
        end
    end

    assign txdata_o = tx_q;
`else
    assign txdata_o = 1'b0;
`endif

endmodule

// File: tb/tb_adf4158_ctrl.sv
// Bench for adf4158_ctrl: scoreboard of expected register words vs serial capture.
// Also checks reset state, timing landmarks, pulse counts and mid-word reset.
module tb_adf4158_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce_o, le_o, clk_o, data_o, txdata_o, done_o;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [31:0] exp_q[$];

    logic [31:0] sr;
    int nbits, le_w, rises, pulses;
    logic prev_sclk, prev_le;

    adf4158_ctrl dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .ce_o    (ce_o),
        .le_o    (le_o),
        .clk_o   (clk_o),
        .data_o  (data_o),
        .txdata_o(txdata_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_words();
        exp_q.delete();
        exp_q.push_back(32'h0000_0007);
        exp_q.push_back(32'h0000_1F46);
        exp_q.push_back(32'h0080_1F46);
        exp_q.push_back(32'h0000_0FFD);
        exp_q.push_back(32'h0080_0005);
        exp_q.push_back(32'h0018_0104);
        exp_q.push_back(32'h0000_0443);
        exp_q.push_back(32'h0700_800A);
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h8030_0000);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) chk("wait_bound", cyc, n);
    endtask

    // Monitor: capture data on clk_o rise, frame and score on le_o rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            sr = '0;
            nbits = 0;
            le_w = 0;
            rises = 0;
            pulses = 0;
            prev_sclk = 1'b0;
            prev_le = 1'b0;
        end else begin
            if (clk_o && !prev_sclk) begin
                sr = {sr[30:0], data_o};
                nbits++;
                rises++;
                chk("le_at_clk_rise", {31'd0, le_o}, 32'd0);
            end
            if (le_o) le_w++;
            if (le_o && !prev_le) begin
                pulses++;
                if (exp_q.size() == 0) chk("unexpected_word", sr, 32'hFFFF_FFFF);
                else chk("word", sr, exp_q.pop_front());
                chk("bits_per_word", nbits, 32);
                nbits = 0;
            end
            if (!le_o && prev_le) begin
                chk("le_width", le_w, 4);
                le_w = 0;
            end
            prev_sclk = clk_o;
            prev_le = le_o;
        end
    end

    function automatic logic [31:0] outs();
        return {26'd0, ce_o, le_o, clk_o, data_o, txdata_o, done_o};
    endfunction

    initial begin
        logic seen;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 32'd0);
        push_words();
        rst_n = 1'b1;

        wait_cyc(1);
        chk("ce_cycle1", {31'd0, ce_o}, 32'd1);
        seen = 1'b0;
        while (cyc < 18) begin
            seen = seen | clk_o;
            @(negedge clk);
        end
        seen = seen | clk_o;
        chk("clk_low_to_18", {31'd0, seen}, 32'd0);
        wait_cyc(19);
        chk("clk_rise_19", {31'd0, clk_o}, 32'd1);
        chk("txdata_before_done", {31'd0, txdata_o}, 32'd0);
        wait_cyc(1376);
        chk("done_1376", {31'd0, done_o}, 32'd0);
        wait_cyc(1377);
        chk("done_1377", {31'd0, done_o}, 32'd1);
        chk("done_outputs", outs(), 32'h21);
        wait_cyc(1400);
        chk("done_held", {31'd0, done_o}, 32'd1);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("clk_rises", rises, 320);
        chk("le_pulses", pulses, 10);
`ifdef ADF4158_TXDATA_EN
        wait_cyc(2376);
        chk("tx_2376", {31'd0, txdata_o}, 32'd0);
        wait_cyc(2377);
        chk("tx_2377", {31'd0, txdata_o}, 32'd1);
        wait_cyc(3376);
        chk("tx_3376", {31'd0, txdata_o}, 32'd1);
        wait_cyc(3377);
        chk("tx_3377", {31'd0, txdata_o}, 32'd0);
`else
        seen = 1'b0;
        while (cyc < 3900) begin
            seen = seen | txdata_o;
            @(negedge clk);
        end
        chk("tx_const0", {31'd0, seen}, 32'd0);
`endif

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        push_words();
        rst_n = 1'b1;
        wait_cyc(485);
        chk("mid_word3_pulses", pulses, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 32'd0);
        repeat (2) @(negedge clk);
        push_words();
        rst_n = 1'b1;
        wait_cyc(1377);
        chk("rerun_done", {31'd0, done_o}, 32'd1);
        wait_cyc(1380);
        chk("rerun_queue_empty", exp_q.size(), 32'd0);
        chk("rerun_rises", rises, 320);
        chk("rerun_pulses", pulses, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
